call_return_unit: RTL and testbench

Subroutine call/return sequencer that drives the push/pop side of the CPU's 32-entry, 10-bit return-address stack. On a call request it pushes the return address (current PC + 1) and redirects the PC to the call target. On a return request it pops the stack and loads the popped address into the PC. Sits between the control unit and the stack; the PC register consumes `pc_load`/`pc_next`.

---
 rtl/callret_pkg.sv | 24 ++
 rtl/callret_depth.sv | 53 +++++
 rtl/call_return_unit.sv | 167 ++++++++++++++++
 tb/tb_call_return_unit.sv | 381 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/callret_pkg.sv
// Shared types and constants for the call/return sequencer.
package callret_pkg;

  localparam int AW    = 10;
  localparam int DEPTH = 32;
  localparam int CW    = $clog2(DEPTH + 1);

  typedef logic [AW-1:0] addr_t;
  typedef logic [CW-1:0] cnt_t;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PUSH = 3'd1,
    POP  = 3'd2,
    WAIT = 3'd3,
    LOAD = 3'd4
  } state_e;

  // Return address of a call: the instruction after the call, wrapping at 2^AW.
  function automatic addr_t next_addr(input addr_t a);
    return a + addr_t'(1);
  endfunction

endpackage

// File: rtl/callret_depth.sv
// Saturating up/down occupancy counter for the return-address stack.
// Counts 0..DEPTH; an increment at full or a decrement at empty is dropped.
module callret_depth
  import callret_pkg::*;
(
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          inc_i,
  input  logic          dec_i,
  output logic [CW-1:0] count_o,
  output logic          full_o,
  output logic          empty_o
);

  cnt_t count_q;
  cnt_t count_d;

  // Next count: step up or down, holding at the limits; inc and dec together cancel.
  always_comb begin
    count_d = count_q;
    case ({inc_i, dec_i})
      2'b10: begin
        if (count_q != cnt_t'(DEPTH)) begin
          count_d = count_q + cnt_t'(1);
        end else begin
          count_d = count_q;
        end
      end
      2'b01: begin
        if (count_q != cnt_t'(0)) begin
          count_d = count_q - cnt_t'(1);
        end else begin
          count_d = count_q;
        end
      end
      default: count_d = count_q;
    endcase
  end

  // Counter register, cleared together with the stack.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= cnt_t'(0);
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign full_o  = (count_q == cnt_t'(DEPTH));
  assign empty_o = (count_q == cnt_t'(0));

endmodule

// File: rtl/call_return_unit.sv
// Subroutine call/return sequencer driving the push/pop side of the
// return-address stack and the PC load port.
// Optional feature macro: CALLRET_GUARD_EN enables the depth counter and the
// overflow/underflow rejection with sticky ovf/unf flags. Without it every
// request proceeds and depth/ovf/unf read as zero.
// All outputs come straight from registers.
module call_return_unit
  import callret_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          call,
  input  logic          ret,
  input  logic [AW-1:0] pc_cur,
  input  logic [AW-1:0] target,
  input  logic [AW-1:0] stack_out,
  output logic [AW-1:0] stack_in,
  output logic          push,
  output logic          pop,
  output logic          pc_load,
  output logic [AW-1:0] pc_next,
  output logic          busy,
  output logic          done,
  output logic          ovf,
  output logic          unf,
  output logic [CW-1:0] depth
);

  state_e state_q, state_d;
  addr_t  tgt_q, tgt_d;
  addr_t  stack_in_q, stack_in_d;   // doubles as the return-address register
  addr_t  pc_next_q, pc_next_d;     // doubles as the popped-address capture
  logic   push_q, push_d;
  logic   pop_q, pop_d;
  logic   pc_load_q, pc_load_d;
  logic   done_q, done_d;
  logic   busy_q, busy_d;
  logic   ovf_q, ovf_d;
  logic   unf_q, unf_d;

  logic   full_s;
  logic   empty_s;
  cnt_t   depth_s;

`ifdef CALLRET_GUARD_EN
  // The counter follows the registered strobes, so depth moves the cycle after push/pop.
  callret_depth u_depth (
    .clk_i   (clk),
    .rst_i   (reset),
    .inc_i   (push_q),
    .dec_i   (pop_q),
    .count_o (depth_s),
    .full_o  (full_s),
    .empty_o (empty_s)
  );
`else
  assign depth_s = cnt_t'(0);
  assign full_s  = 1'b0;
  assign empty_s = 1'b0;
`endif

  // Next-state and next-output logic; strobes default low so each is one cycle wide.
  always_comb begin
    state_d    = state_q;
    tgt_d      = tgt_q;
    stack_in_d = stack_in_q;
    pc_next_d  = pc_next_q;
    push_d     = 1'b0;
    pop_d      = 1'b0;
    pc_load_d  = 1'b0;
    done_d     = 1'b0;
    ovf_d      = ovf_q;
    unf_d      = unf_q;
    case (state_q)
      IDLE: begin
        if (call) begin
          // call has priority; a simultaneous ret is dropped
          if (full_s) begin
            ovf_d   = 1'b1;
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            stack_in_d = next_addr(pc_cur);
            tgt_d      = target;
            push_d     = 1'b1;
            state_d    = PUSH;
          end
        end else if (ret) begin
          if (empty_s) begin
            unf_d   = 1'b1;
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            pop_d   = 1'b1;
            state_d = POP;
          end
        end else begin
          state_d = IDLE;
        end
      end
      PUSH: begin
        pc_next_d = tgt_q;
        pc_load_d = 1'b1;
        done_d    = 1'b1;
        state_d   = LOAD;
      end
      POP: begin
        state_d = WAIT;
      end
      WAIT: begin
        // stack_out is valid exactly one cycle after the pop strobe
        pc_next_d = stack_out;
        pc_load_d = 1'b1;
        done_d    = 1'b1;
        state_d   = LOAD;
      end
      LOAD: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and output registers; reset abandons any sequence in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      tgt_q      <= addr_t'(0);
      stack_in_q <= addr_t'(0);
      pc_next_q  <= addr_t'(0);
      push_q     <= 1'b0;
      pop_q      <= 1'b0;
      pc_load_q  <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      tgt_q      <= tgt_d;
      stack_in_q <= stack_in_d;
      pc_next_q  <= pc_next_d;
      push_q     <= push_d;
      pop_q      <= pop_d;
      pc_load_q  <= pc_load_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
      ovf_q      <= ovf_d;
      unf_q      <= unf_d;
    end
  end

  assign stack_in = stack_in_q;
  assign push     = push_q;
  assign pop      = pop_q;
  assign pc_load  = pc_load_q;
  assign pc_next  = pc_next_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign ovf      = ovf_q;
  assign unf      = unf_q;
  assign depth    = depth_s;

endmodule

// File: tb/tb_call_return_unit.sv
// Self-checking bench for call_return_unit: a transaction-level model queues
// the expected per-cycle outputs for each request; a compare process checks
// them every cycle, and a few literal checks pin the model.
module tb_call_return_unit;

`ifdef CALLRET_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic       clk;
  logic       reset;
  logic       call;
  logic       ret;
  logic [9:0] pc_cur;
  logic [9:0] target;
  logic [9:0] stack_out;
  logic [9:0] stack_in;
  logic       push;
  logic       pop;
  logic       pc_load;
  logic [9:0] pc_next;
  logic       busy;
  logic       done;
  logic       ovf;
  logic       unf;
  logic [5:0] depth;

  call_return_unit dut (
    .clk       (clk),
    .reset     (reset),
    .call      (call),
    .ret       (ret),
    .pc_cur    (pc_cur),
    .target    (target),
    .stack_out (stack_out),
    .stack_in  (stack_in),
    .push      (push),
    .pop       (pop),
    .pc_load   (pc_load),
    .pc_next   (pc_next),
    .busy      (busy),
    .done      (done),
    .ovf       (ovf),
    .unf       (unf),
    .depth     (depth)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- emulated return-address stack ----------------
  logic [9:0] emu_mem [32];
  logic [4:0] emu_sp;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      emu_sp    <= 5'd0;
      stack_out <= 10'd0;
    end else if (push) begin
      emu_mem[emu_sp] <= stack_in;
      emu_sp          <= emu_sp + 5'd1;
    end else if (pop) begin
      stack_out <= emu_mem[emu_sp - 5'd1];
      emu_sp    <= emu_sp - 5'd1;
    end
  end

  // ---------------- checking infrastructure ----------------
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  typedef struct packed {
    logic       push;
    logic       pop;
    logic       pc_load;
    logic       done;
    logic       busy;
    logic       ovf;
    logic       unf;
    logic [5:0] depth;
    logic [9:0] stack_in;
    logic [9:0] pc_next;
  } exp_t;

  // Model state: a LIFO of return addresses plus sticky flags.
  logic [9:0] m_mem [32];
  int         m_sp;
  int         m_depth;
  logic       m_ovf;
  logic       m_unf;
  exp_t       exp_q [$];
  exp_t       cur_e;
  logic       cur_v;
  bit         chk_en;

  function automatic exp_t idle_exp();
    exp_t e;
    e          = '0;
    e.ovf      = m_ovf;
    e.unf      = m_unf;
    e.depth    = 6'(m_depth);
    return e;
  endfunction

  task automatic model_reset();
    m_sp    = 0;
    m_depth = 0;
    m_ovf   = 1'b0;
    m_unf   = 1'b0;
    exp_q.delete();
  endtask

  // Take the expectation for the cycle that starts at this edge.
  always @(posedge clk) begin
    if (exp_q.size() > 0) begin
      cur_e <= exp_q.pop_front();
      cur_v <= 1'b1;
    end else begin
      cur_v <= 1'b0;
    end
  end

  // Compare DUT outputs against the model mid-cycle.
  always @(negedge clk) begin : cmp_blk
    exp_t e;
    if (chk_en) begin
      e = cur_v ? cur_e : idle_exp();
      chk("push",    {31'd0, push},    {31'd0, e.push});
      chk("pop",     {31'd0, pop},     {31'd0, e.pop});
      chk("pc_load", {31'd0, pc_load}, {31'd0, e.pc_load});
      chk("done",    {31'd0, done},    {31'd0, e.done});
      chk("busy",    {31'd0, busy},    {31'd0, e.busy});
      chk("ovf",     {31'd0, ovf},     {31'd0, e.ovf});
      chk("unf",     {31'd0, unf},     {31'd0, e.unf});
      chk("depth",   {26'd0, depth},   {26'd0, e.depth});
      if (e.push)    chk("stack_in", {22'd0, stack_in}, {22'd0, e.stack_in});
      if (e.pc_load) chk("pc_next",  {22'd0, pc_next},  {22'd0, e.pc_next});
    end
  end

  // Event monitor used by the literal checks.
  int         n_push = 0;
  int         n_pop  = 0;
  int         n_load = 0;
  logic [9:0] last_push = 10'd0;
  logic [9:0] last_load = 10'd0;

  always @(negedge clk) begin
    if (push) begin
      n_push++;
      last_push = stack_in;
    end
    if (pop) n_pop++;
    if (pc_load) begin
      n_load++;
      last_load = pc_next;
    end
  end

  // ---------------- request tasks (start and end at posedge+2) ----------------
  task automatic do_call(input logic [9:0] pc, input logic [9:0] tg, input bit with_ret, input bit poke);
    exp_t       e;
    logic [9:0] ra;
    call   = 1'b1;
    ret    = with_ret;
    pc_cur = pc;
    target = tg;
    if (GUARD && m_depth == 32) begin
      e = idle_exp(); e.done = 1'b1; e.ovf = 1'b1;
      exp_q.push_back(e);
      @(posedge clk); #2;
      call  = 1'b0; ret = 1'b0;
      m_ovf = 1'b1;
    end else begin
      ra = pc + 10'd1;
      e = idle_exp(); e.push = 1'b1; e.busy = 1'b1; e.stack_in = ra;
      exp_q.push_back(e);
      e = idle_exp(); e.pc_load = 1'b1; e.done = 1'b1; e.busy = 1'b1; e.pc_next = tg;
      e.depth = 6'(m_depth + (GUARD ? 1 : 0));
      exp_q.push_back(e);
      @(posedge clk); #2;
      if (poke) begin
        call = 1'b1; ret = 1'b1; pc_cur = ~pc; target = ~tg;
      end else begin
        call = 1'b0; ret = 1'b0;
      end
      @(posedge clk); #2;
      @(posedge clk); #2;
      call = 1'b0; ret = 1'b0;
      m_mem[m_sp] = ra;
      m_sp        = (m_sp + 1) % 32;
      if (GUARD) m_depth = m_depth + 1;
    end
  endtask

  task automatic do_ret();
    exp_t       e;
    logic [9:0] v;
    int         nd;
    ret = 1'b1;
    if (GUARD && m_depth == 0) begin
      e = idle_exp(); e.done = 1'b1; e.unf = 1'b1;
      exp_q.push_back(e);
      @(posedge clk); #2;
      ret   = 1'b0;
      m_unf = 1'b1;
    end else begin
      m_sp = (m_sp + 31) % 32;
      v    = m_mem[m_sp];
      nd   = GUARD ? m_depth - 1 : 0;
      e = idle_exp(); e.pop = 1'b1; e.busy = 1'b1;
      exp_q.push_back(e);
      e = idle_exp(); e.busy = 1'b1; e.depth = 6'(nd);
      exp_q.push_back(e);
      e = idle_exp(); e.busy = 1'b1; e.pc_load = 1'b1; e.done = 1'b1; e.pc_next = v; e.depth = 6'(nd);
      exp_q.push_back(e);
      @(posedge clk); #2;
      ret = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      m_depth = nd;
    end
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    model_reset();
    @(posedge clk); #2;
    reset = 1'b0;
  endtask

  // Global time bound.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed stimulus ----------------
  initial begin
    int np, npo, nl;
    call   = 1'b0;
    ret    = 1'b0;
    pc_cur = 10'd0;
    target = 10'd0;
    cur_v  = 1'b0;
    cur_e  = '0;
    chk_en = 1'b1;
    model_reset();
    reset  = 1'b1;
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
    @(posedge clk); #2;

    // reset values
    chk("rst_stack_in", {22'd0, stack_in}, 32'h0);
    chk("rst_pc_next",  {22'd0, pc_next},  32'h0);
    chk("rst_depth",    {26'd0, depth},    32'h0);
    chk("rst_busy",     {31'd0, busy},     32'h0);

    // basic call and return
    np = n_push;
    do_call(10'h010, 10'h200, 1'b0, 1'b0);
    chk("call1_push_val", {22'd0, last_push}, 32'h011);
    chk("call1_pc_next",  {22'd0, last_load}, 32'h200);
    chk("call1_npush",    n_push - np,        32'd1);
`ifdef CALLRET_GUARD_EN
    chk("call1_depth",    {26'd0, depth},     32'd1);
`endif
    do_ret();
    chk("ret1_pc_next", {22'd0, last_load}, 32'h011);
    chk("ret1_depth",   {26'd0, depth},     32'd0);

    // return-address wrap
    do_call(10'h3FF, 10'h123, 1'b0, 1'b0);
    chk("wrap_push_val", {22'd0, last_push}, 32'h000);
    do_ret();
    chk("wrap_ret_val",  {22'd0, last_load}, 32'h000);

    // simultaneous call and ret: call wins
    npo = n_pop;
    do_call(10'h050, 10'h060, 1'b1, 1'b0);
    chk("sim_no_pop",  n_pop - npo,        32'd0);
    chk("sim_pc_next", {22'd0, last_load}, 32'h060);

    // requests while busy are ignored
    np  = n_push;
    npo = n_pop;
    do_call(10'h070, 10'h080, 1'b0, 1'b1);
    chk("busy_npush", n_push - np, 32'd1);
    chk("busy_npop",  n_pop - npo, 32'd0);
    do_ret();
    chk("nest_ret1", {22'd0, last_load}, 32'h071);
    do_ret();
    chk("nest_ret2", {22'd0, last_load}, 32'h051);

    // fill the stack, then one more call
    np = n_push;
    for (int i = 0; i < 32; i++) begin
      do_call(10'(i), 10'(256 + i), 1'b0, 1'b0);
    end
    nl = n_load;
    do_call(10'h3A0, 10'h3B0, 1'b0, 1'b0);
`ifdef CALLRET_GUARD_EN
    chk("full_npush",   n_push - np,       32'd32);
    chk("full_no_load", n_load - nl,       32'd0);
    chk("full_ovf",     {31'd0, ovf},      32'd1);
    chk("full_depth",   {26'd0, depth},    32'd32);
    do_ret();
    chk("full_ret_val", {22'd0, last_load}, 32'h020);
`else
    chk("nog_npush",    n_push - np,       32'd33);
    chk("nog_load",     n_load - nl,       32'd1);
    chk("nog_ovf",      {31'd0, ovf},      32'd0);
    do_ret();
    chk("nog_ret_val",  {22'd0, last_load}, 32'h3A1);
`endif

    // return on an empty stack
    apply_reset();
    npo = n_pop;
    do_ret();
`ifdef CALLRET_GUARD_EN
    chk("unf_flag",   {31'd0, unf}, 32'd1);
    chk("unf_no_pop", n_pop - npo,  32'd0);
`else
    chk("nog_unf",    {31'd0, unf}, 32'd0);
    chk("nog_pop",    n_pop - npo,  32'd1);
`endif

    // reset while waiting for stack_out
    apply_reset();
    do_call(10'h123, 10'h234, 1'b0, 1'b0);
    nl     = n_load;
    chk_en = 1'b0;
    ret    = 1'b1;
    @(posedge clk); #2;
    ret = 1'b0;
    @(posedge clk); #2;
    chk("wait_busy", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    model_reset();
    #1;
    chk("rstw_push",     {31'd0, push},     32'd0);
    chk("rstw_pop",      {31'd0, pop},      32'd0);
    chk("rstw_pc_load",  {31'd0, pc_load},  32'd0);
    chk("rstw_done",     {31'd0, done},     32'd0);
    chk("rstw_busy",     {31'd0, busy},     32'd0);
    chk("rstw_depth",    {26'd0, depth},    32'd0);
    chk("rstw_pc_next",  {22'd0, pc_next},  32'd0);
    chk("rstw_stack_in", {22'd0, stack_in}, 32'd0);
    @(posedge clk); #2;
    reset  = 1'b0;
    chk_en = 1'b1;
    repeat (4) @(posedge clk);
    #2;
    chk("rstw_no_load", n_load - nl, 32'd0);

    // normal operation after reset
    do_call(10'h001, 10'h002, 1'b0, 1'b0);
    chk("post_push_val", {22'd0, last_push}, 32'h002);
    chk("post_pc_next",  {22'd0, last_load}, 32'h002);
    do_ret();
    chk("post_ret_val",  {22'd0, last_load}, 32'h002);

    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
